sap_ram_loader: RTL and testbench
=================================

// Module: sap_ram_loader
// PURPOSE
//  Parametrised SAP-1 program/data RAM with active-low bus strobes and a
//  one-cycle registered read. Adds a program-load engine that fills memory
//  sequentially from a valid/ready byte stream, and a bulk-clear engine.
//  Sits between the W-bus (through a top-level tri-state on data_out/data_oe)
//  and the front-panel loader.
// PARAMETERS
//  ADDR_W   4     address width; DEPTH = 2**ADDR_W words (localparam)
//  DATA_W   8     word width
//  CLR_VAL  0     value written to every word by the clear engine (DATA_W bits)
// PORTS
//  CLK         in   1       system clock, all state updates on rising edge
//  RST         in   1       asynchronous, active-high reset
//  nCe         in   1       chip enable, active low (run mode only)
//  nrd         in   1       read strobe, active low
//  nwr         in   1       write strobe, active low
//  addr        in   ADDR_W  bus address
//  data_in     in   DATA_W  bus write data
//  data_out    out  DATA_W  registered read data
//  data_oe     out  1       drive enable for top-level tri-state of data_out
//  bus_err     out  1       1-cycle pulse: nCe=0 with nrd=0 and nwr=0
//  prog_start  in   1       start sequential load (sampled in IDLE only)
//  prog_abort  in   1       abandon load, return to IDLE
//  prog_valid  in   1       prog_data valid
//  prog_data   in   DATA_W  load word
//  prog_ready  out  1       loader accepts a word this cycle
//  clr_start   in   1       start bulk clear (sampled in IDLE only)
//  busy        out  1       1 whenever state != IDLE
//  done        out  1       1-cycle pulse on completion of load or clear
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=0; data_out=0, data_oe=0, bus_err=0,
//    prog_ready=0, busy=0, done=0. Memory array is NOT reset (contents hold).
//  - FSM states: IDLE, PROG, CLEAR. ptr is ADDR_W bits.
//  - IDLE, run-mode bus (combinational decode, registered effect):
//    nCe=0,nwr=0,nrd=1: mem[addr] <= data_in at edge.
//    nCe=0,nrd=0,nwr=1: data_out <= mem[addr] at edge; data_oe <= 1 at
//      same edge (data valid + driven the cycle after the strobe).
//    nCe=0,nrd=0,nwr=0: no write, no read, data_oe <= 0, bus_err <= 1.
//    otherwise: data_oe <= 0; data_out holds last value.
//    Read of address just written in the previous cycle returns new data.
//  - IDLE transitions: clr_start=1 -> CLEAR; else prog_start=1 -> PROG
//    (clear wins if both). ptr <= 0 on entry. Bus strobes in the same cycle
//    as a start are still honoured.
//  - PROG: prog_ready=1, bus ignored, data_oe=0. On prog_valid&prog_ready:
//    mem[ptr] <= prog_data, ptr <= ptr+1. Word accepted at ptr=DEPTH-1 ->
//    done=1 next cycle, state -> IDLE, ptr wraps to 0. No valid: wait.
//    prog_abort=1 (priority over a same-cycle word: word not written) ->
//    IDLE, no done, already-written words kept.
//  - CLEAR: one word per cycle, mem[ptr] <= CLR_VAL, ptr++; exactly DEPTH
//    cycles; after ptr=DEPTH-1 -> IDLE with done=1. prog_abort ignored;
//    prog_ready=0; bus ignored.
//  - busy combinational from state; done/bus_err registered pulses.
//  - RST asserted mid-PROG/CLEAR: immediate IDLE, no done, partial memory
//    contents retained.
// TESTING
//  1 RST then nCe=0,nwr=0,addr=5,data_in=0xDC one cycle; nCe=0,nrd=0,addr=5
//    -> next cycle data_out=0xDC, data_oe=1; nCe=1 -> data_oe=0, out holds.
//  2 nCe=0,nrd=0,nwr=0,addr=3 -> bus_err pulse 1 cycle, mem[3] unchanged,
//    data_oe=0.
//  3 prog_start; stream 0x00..0x0F with prog_valid gaps every 3rd cycle ->
//    busy during load, done one cycle after 16th word, reads addr k = k.
//  4 prog_start, 6 words 0xA0..0xA5, prog_abort with valid 7th word ->
//    IDLE, no done, mem[0..5]=0xA0..0xA5, mem[6] unchanged.
//  5 clr_start and prog_start together (CLR_VAL=0) -> CLEAR, busy exactly
//    16 cycles, done pulse, all reads return 0x00.
//  6 RST at ptr=8 during PROG, then ADDR_W=5,DATA_W=16 build repeats 1,3
//    -> outputs at reset values, mem[0..7] kept; 32-word load completes.

Source files
------------

// File: rtl/sap_ram_loader.sv
// SAP-1 program/data RAM with active-low bus strobes and a registered read port,
// plus a sequential valid/ready program loader and a bulk-clear engine.
module sap_ram_loader #(
    parameter int unsigned       ADDR_W  = 4,
    parameter int unsigned       DATA_W  = 8,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              nCe,
    input  logic              nrd,
    input  logic              nwr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              bus_err,
    input  logic              prog_start,
    input  logic              prog_abort,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    input  logic              clr_start,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        PROG,
        CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              bus_sel;
    logic              bus_wr;
    logic              bus_rd;
    logic              bus_conflict;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // The run-mode bus is only decoded while no engine owns the memory.
    assign bus_sel      = (state == IDLE) && !nCe;
    assign bus_wr       = bus_sel && !nwr &&  nrd;
    assign bus_rd       = bus_sel && !nrd &&  nwr;
    assign bus_conflict = bus_sel && !nrd && !nwr;

    assign busy       = (state != IDLE);
    assign prog_ready = (state == PROG);

    // Single write port shared by the bus, the loader and the clear engine.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = data_in;
        unique case (state)
            IDLE: mem_we = bus_wr;
            PROG: begin
                mem_we    = prog_valid && !prog_abort;
                mem_waddr = ptr;
                mem_wdata = prog_data;
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr;
                mem_wdata = CLR_VAL;
            end
            default: mem_we = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            ptr      <= '0;
            data_out <= '0;
            data_oe  <= 1'b0;
            bus_err  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done    <= 1'b0;
            bus_err <= 1'b0;
            data_oe <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus_rd) begin
                        data_out <= mem[addr];
                        data_oe  <= 1'b1;
                    end
                    bus_err <= bus_conflict;
                    ptr     <= '0;
                    if (clr_start) begin
                        state <= CLEAR;
                    end else if (prog_start) begin
                        state <= PROG;
                    end
                end
                PROG: begin
                    // Abort outranks a word presented in the same cycle.
                    if (prog_abort) begin
                        state <= IDLE;
                    end else if (prog_valid) begin
                        ptr <= ptr + 1'b1;
                        if (ptr == LAST_PTR) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_PTR) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_ram_loader.sv
// Bench for sap_ram_loader: a 16x8 and a 32x16 instance checked each cycle
// against a word-array model, plus directed literal expectations.
module tb_sap_ram_loader;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [1:0]  nce, nrd, nwr, pstart, pabort, pvalid, cstart;
    logic [4:0]  addr  [2];
    logic [15:0] din   [2];
    logic [15:0] pdata [2];
    logic [1:0]  oe, err, ready, busy, done;
    logic [7:0]  dout0;
    logic [15:0] dout1;
    logic [15:0] dout  [2];

    always_comb begin
        dout[0] = {8'h00, dout0};
        dout[1] = dout1;
    end

    sap_ram_loader #(.ADDR_W(4), .DATA_W(8), .CLR_VAL(8'h00)) dut0 (
        .CLK(CLK), .RST(RST), .nCe(nce[0]), .nrd(nrd[0]), .nwr(nwr[0]),
        .addr(addr[0][3:0]), .data_in(din[0][7:0]), .data_out(dout0),
        .data_oe(oe[0]), .bus_err(err[0]), .prog_start(pstart[0]),
        .prog_abort(pabort[0]), .prog_valid(pvalid[0]), .prog_data(pdata[0][7:0]),
        .prog_ready(ready[0]), .clr_start(cstart[0]), .busy(busy[0]), .done(done[0])
    );

    sap_ram_loader #(.ADDR_W(5), .DATA_W(16), .CLR_VAL(16'h0000)) dut1 (
        .CLK(CLK), .RST(RST), .nCe(nce[1]), .nrd(nrd[1]), .nwr(nwr[1]),
        .addr(addr[1]), .data_in(din[1]), .data_out(dout1),
        .data_oe(oe[1]), .bus_err(err[1]), .prog_start(pstart[1]),
        .prog_abort(pabort[1]), .prog_valid(pvalid[1]), .prog_data(pdata[1]),
        .prog_ready(ready[1]), .clr_start(cstart[1]), .busy(busy[1]), .done(done[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int d, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE  = 0;
    localparam int M_PROG  = 1;
    localparam int M_CLEAR = 2;

    logic [15:0] mmem   [2][32];
    bit          mknown [2][32];
    int          mmode  [2];
    int          mcnt   [2];
    logic [15:0] e_dout [2];
    bit          e_dknown [2];
    bit          e_oe   [2];
    bit          e_err  [2];
    bit          e_done [2];

    task automatic model_step(input int d);
        int          depth;
        int          a;
        logic [15:0] dmask;
        depth = (d == 0) ? 16 : 32;
        dmask = (d == 0) ? 16'h00FF : 16'hFFFF;
        a     = int'(addr[d]) % depth;
        e_done[d] = 0;
        e_err[d]  = 0;
        e_oe[d]   = 0;
        if (RST) begin
            mmode[d]    = M_IDLE;
            mcnt[d]     = 0;
            e_dout[d]   = 16'h0000;
            e_dknown[d] = 1;
        end else if (mmode[d] == M_IDLE) begin
            if (!nce[d] && !nwr[d] && nrd[d]) begin
                mmem[d][a]   = din[d] & dmask;
                mknown[d][a] = 1;
            end else if (!nce[d] && !nrd[d] && nwr[d]) begin
                e_dout[d]   = mmem[d][a];
                e_dknown[d] = mknown[d][a];
                e_oe[d]     = 1;
            end else if (!nce[d] && !nrd[d] && !nwr[d]) begin
                e_err[d] = 1;
            end
            mcnt[d] = 0;
            if (cstart[d])      mmode[d] = M_CLEAR;
            else if (pstart[d]) mmode[d] = M_PROG;
        end else if (mmode[d] == M_PROG) begin
            if (pabort[d]) begin
                mmode[d] = M_IDLE;
            end else if (pvalid[d]) begin
                mmem[d][mcnt[d]]   = pdata[d] & dmask;
                mknown[d][mcnt[d]] = 1;
                mcnt[d]++;
                if (mcnt[d] == depth) begin
                    mcnt[d]   = 0;
                    mmode[d]  = M_IDLE;
                    e_done[d] = 1;
                end
            end
        end else begin
            mmem[d][mcnt[d]]   = 16'h0000;
            mknown[d][mcnt[d]] = 1;
            mcnt[d]++;
            if (mcnt[d] == depth) begin
                mcnt[d]   = 0;
                mmode[d]  = M_IDLE;
                e_done[d] = 1;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mmode[d] = M_IDLE;
            mcnt[d]  = 0;
            e_dknown[d] = 0;
            for (int i = 0; i < 32; i++) mknown[d][i] = 0;
        end
    end

    always @(posedge CLK) begin
        for (int d = 0; d < 2; d++) model_step(d);
    end

    always @(posedge CLK) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            if (e_dknown[d]) chk("data_out", d, dout[d], e_dout[d]);
            chk("data_oe",    d, 16'(oe[d]),    16'(e_oe[d]));
            chk("bus_err",    d, 16'(err[d]),   16'(e_err[d]));
            chk("done",       d, 16'(done[d]),  16'(e_done[d]));
            chk("busy",       d, 16'(busy[d]),  16'(mmode[d] != M_IDLE));
            chk("prog_ready", d, 16'(ready[d]), 16'(mmode[d] == M_PROG));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic rel(input int d);
        nce[d] = 1; nrd[d] = 1; nwr[d] = 1;
        pstart[d] = 0; cstart[d] = 0; pvalid[d] = 0; pabort[d] = 0;
    endtask

    task automatic wr(input int d, input int a, input logic [15:0] v);
        nce[d] = 0; nwr[d] = 0; nrd[d] = 1; addr[d] = 5'(a); din[d] = v;
        cyc();
        rel(d);
    endtask

    task automatic rd(input int d, input int a);
        nce[d] = 0; nrd[d] = 0; nwr[d] = 1; addr[d] = 5'(a);
        cyc();
        rel(d);
    endtask

    // Streams n words base+k; with gap>0 every gap-th cycle has no valid.
    task automatic load(input int d, input int n, input logic [15:0] base, input int gap);
        int k = 0;
        int c = 0;
        int guard = 0;
        pstart[d] = 1;
        cyc();
        pstart[d] = 0;
        while (k < n && guard < 400) begin
            guard++;
            c++;
            chk("busy_in_load", d, 16'(busy[d]), 16'h1);
            if (gap != 0 && c % gap == 0) begin
                pvalid[d] = 0;
            end else begin
                pvalid[d] = 1;
                pdata[d]  = base + 16'(k);
            end
            if (pvalid[d] && ready[d]) k++;
            cyc();
        end
        pvalid[d] = 0;
        chk("load_words", d, 16'(k), 16'(n));
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            rel(d);
            addr[d] = '0; din[d] = '0; pdata[d] = '0;
        end
        cyc(); cyc();
        RST = 0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_dout", d, dout[d], 16'h0);
            chk("rst_oe",   d, 16'(oe[d]),   16'h0);
            chk("rst_busy", d, 16'(busy[d]), 16'h0);
            chk("rst_rdy",  d, 16'(ready[d]), 16'h0);
            chk("rst_done", d, 16'(done[d]), 16'h0);
        end

        // 1: write then immediate read, then deselect
        wr(0, 5, 16'h00DC);
        rd(0, 5);
        chk("t1_dout", 0, dout[0], 16'h00DC);
        chk("t1_oe",   0, 16'(oe[0]), 16'h1);
        cyc();
        chk("t1_oe_off", 0, 16'(oe[0]), 16'h0);
        chk("t1_hold",   0, dout[0], 16'h00DC);

        // 2: both strobes low -> error pulse, no write
        wr(0, 3, 16'h0033);
        nce[0] = 0; nrd[0] = 0; nwr[0] = 0; addr[0] = 5'd3; din[0] = 16'h0099;
        cyc();
        rel(0);
        chk("t2_err", 0, 16'(err[0]), 16'h1);
        chk("t2_oe",  0, 16'(oe[0]),  16'h0);
        cyc();
        chk("t2_err_off", 0, 16'(err[0]), 16'h0);
        rd(0, 3);
        chk("t2_mem3", 0, dout[0], 16'h0033);

        // 3: full load with gaps
        load(0, 16, 16'h0000, 3);
        chk("t3_done", 0, 16'(done[0]), 16'h1);
        chk("t3_idle", 0, 16'(busy[0]), 16'h0);
        cyc();
        chk("t3_done_off", 0, 16'(done[0]), 16'h0);
        for (int k = 0; k < 16; k++) begin
            rd(0, k);
            chk("t3_read", 0, dout[0], 16'(k));
        end

        // 4: abort with a word presented in the same cycle
        load(0, 6, 16'h00A0, 0);
        pvalid[0] = 1; pdata[0] = 16'h00A6; pabort[0] = 1;
        cyc();
        rel(0);
        chk("t4_idle", 0, 16'(busy[0]), 16'h0);
        chk("t4_done", 0, 16'(done[0]), 16'h0);
        for (int k = 0; k < 7; k++) begin
            rd(0, k);
            chk("t4_read", 0, dout[0], (k < 6) ? 16'h00A0 + 16'(k) : 16'h0006);
        end

        // 5: clear wins over a simultaneous program start
        cstart[0] = 1; pstart[0] = 1;
        cyc();
        rel(0);
        n = 0;
        while (busy[0] && n < 40) begin
            chk("t5_rdy", 0, 16'(ready[0]), 16'h0);
            n++;
            cyc();
        end
        chk("t5_cycles", 0, 16'(n), 16'd16);
        chk("t5_done",   0, 16'(done[0]), 16'h1);
        for (int k = 0; k < 16; k++) begin
            rd(0, k);
            chk("t5_read", 0, dout[0], 16'h0000);
        end

        // 6: reset in the middle of a load keeps the words already written
        load(0, 8, 16'h0050, 0);
        RST = 1;
        #1;
        chk("t6_busy", 0, 16'(busy[0]),  16'h0);
        chk("t6_rdy",  0, 16'(ready[0]), 16'h0);
        chk("t6_done", 0, 16'(done[0]),  16'h0);
        chk("t6_dout", 0, dout[0], 16'h0);
        cyc();
        RST = 0;
        cyc();
        for (int k = 0; k < 8; k++) begin
            rd(0, k);
            chk("t6_read", 0, dout[0], 16'h0050 + 16'(k));
        end

        // wide build: write/read and a full 32-word load
        wr(1, 21, 16'hBEEF);
        rd(1, 21);
        chk("w1_dout", 1, dout[1], 16'hBEEF);
        chk("w1_oe",   1, 16'(oe[1]), 16'h1);
        cyc();
        chk("w1_oe_off", 1, 16'(oe[1]), 16'h0);
        load(1, 32, 16'h1000, 3);
        chk("w3_done", 1, 16'(done[1]), 16'h1);
        cyc();
        for (int k = 0; k < 32; k++) begin
            rd(1, k);
            chk("w3_read", 1, dout[1], 16'h1000 + 16'(k));
        end

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
